chase_sequencer: RTL and testbench

Timing and position controller for the segment-chaser fade/PWM datapath. It generates the step strobe and the current head position index, and the fade datapath maps that index onto a segment ring and lights it. It also owns the step-period counter, the direction/bounce/single-shot mode logic and a valid/ready configuration port, so the datapath needs no speed or direction pins of its own. It sits between the TinyTapeout input-pin decoder (or a register interface) and the fade datapath.

---
 rtl/chase_sequencer.sv | 175 +++++++++++++++++
 tb/tb_chase_sequencer.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/chase_sequencer.sv
// chase_sequencer: step-period timer, head-position sequencer and
// valid/ready configuration port for the segment-chaser fade datapath.
module chase_sequencer #(
  parameter int PERIOD_WIDTH = 23
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       cfg_valid,
  output logic       cfg_ready,
  input  logic [2:0] cfg_speed,
  input  logic [1:0] cfg_mode,
  input  logic       cfg_run,
  output logic       step_o,
  output logic [2:0] head,
  output logic       head_valid,
  output logic       busy,
  output logic       done
);

  // state | meaning
  // IDLE  | stopped, head blanked; an accepted config is applied next edge
  // RUN   | period counter running, head advances at every boundary
  // DONE  | single-shot pass finished, head parked at 7 and still shown
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  localparam logic [1:0] M_FWD = 2'b00;
  localparam logic [1:0] M_REV = 2'b01;
  localparam logic [1:0] M_BNC = 2'b10;
  localparam logic [1:0] M_ONE = 2'b11;
  localparam logic [PERIOD_WIDTH-1:0] ONE = PERIOD_WIDTH'(1);

  state_t                  state;
  logic [PERIOD_WIDTH-1:0] cnt;
  logic [PERIOD_WIDTH-1:0] term;
  logic [2:0]              act_speed;
  logic [1:0]              act_mode;
  logic                    dir_up;
  logic                    pend;
  logic [2:0]              pend_speed;
  logic [1:0]              pend_mode;
  logic                    pend_run;
  logic                    accept;
  logic                    boundary;
  logic [3:0]              adv_act;

  // Returns {direction_up, next_head} for one step in the given mode.
  // Bounce turns at the endpoints without repeating them.
  function automatic logic [3:0] advance(input logic [1:0] mode,
                                         input logic [2:0] h,
                                         input logic       up);
    logic [2:0] nh;
    logic       nu;
    nh = h + 3'd1;
    nu = up;
    case (mode)
      M_REV: nh = h - 3'd1;
      M_BNC: begin
        if (up) begin
          if (h == 3'd7) begin
            nh = 3'd6;
            nu = 1'b0;
          end else begin
            nh = h + 3'd1;
          end
        end else begin
          if (h == 3'd0) begin
            nh = 3'd1;
            nu = 1'b1;
          end else begin
            nh = h - 3'd1;
          end
        end
      end
      default: nh = h + 3'd1;
    endcase
    return {nu, nh};
  endfunction

  // Speed 7 wraps (s+1)<<(W-3) to zero, so the -1 lands on all ones.
  assign term      = ((PERIOD_WIDTH'(act_speed) + ONE) << (PERIOD_WIDTH - 3)) - ONE;
  assign cfg_ready = ~pend;
  assign accept    = cfg_valid & cfg_ready;
  assign boundary  = (cnt == term);
  assign adv_act   = advance(act_mode, head, dir_up);

  // Sequencer FSM: period timer, head stepping and config hand-over.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      cnt        <= '0;
      head       <= 3'd0;
      head_valid <= 1'b0;
      step_o     <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      dir_up     <= 1'b1;
      act_speed  <= 3'd0;
      act_mode   <= M_FWD;
      pend       <= 1'b0;
      pend_speed <= 3'd0;
      pend_mode  <= M_FWD;
      pend_run   <= 1'b0;
    end else begin
      step_o <= 1'b0;
      done   <= 1'b0;
      case (state)
        RUN: begin
          if (boundary) begin
            cnt <= '0;
            if (pend) begin
              pend      <= 1'b0;
              act_speed <= pend_speed;
              act_mode  <= pend_mode;
              if (!pend_run) begin
                state      <= IDLE;
                head_valid <= 1'b0;
                busy       <= 1'b0;
                dir_up     <= 1'b1;
              end else if (pend_mode == M_ONE) begin
                step_o <= 1'b1;
                head   <= 3'd0;
                dir_up <= 1'b1;
              end else begin
                step_o         <= 1'b1;
                {dir_up, head} <= advance(pend_mode, head, 1'b1);
              end
            end else begin
              step_o         <= 1'b1;
              {dir_up, head} <= adv_act;
              if (act_mode == M_ONE && adv_act[2:0] == 3'd7) begin
                state <= DONE;
                done  <= 1'b1;
                busy  <= 1'b0;
              end
            end
          end else begin
            cnt <= cnt + ONE;
          end
          // Only reachable with no pending config, so it never races the
          // hand-over above: a boundary on the accept cycle uses the old one.
          if (accept) begin
            pend       <= 1'b1;
            pend_speed <= cfg_speed;
            pend_mode  <= cfg_mode;
            pend_run   <= cfg_run;
          end
        end
        default: begin
          if (pend) begin
            pend      <= 1'b0;
            act_speed <= pend_speed;
            act_mode  <= pend_mode;
            dir_up    <= 1'b1;
            cnt       <= '0;
            if (pend_run) begin
              state      <= RUN;
              busy       <= 1'b1;
              head_valid <= 1'b1;
              head       <= (pend_mode == M_REV) ? 3'd7 : 3'd0;
            end else begin
              state      <= IDLE;
              head_valid <= 1'b0;
            end
          end else if (accept) begin
            pend       <= 1'b1;
            pend_speed <= cfg_speed;
            pend_mode  <= cfg_mode;
            pend_run   <= cfg_run;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_chase_sequencer.sv
// tb_chase_sequencer: directed scenarios plus random config traffic, checked
// every cycle against a period/phase model of the chaser.
module tb_chase_sequencer;

  localparam int PW = 6;

  logic       clk;
  logic       reset_n;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [2:0] cfg_speed;
  logic [1:0] cfg_mode;
  logic       cfg_run;
  logic       step_o;
  logic [2:0] head;
  logic       head_valid;
  logic       busy;
  logic       done;

  chase_sequencer #(.PERIOD_WIDTH(PW)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_speed  (cfg_speed),
    .cfg_mode   (cfg_mode),
    .cfg_run    (cfg_run),
    .step_o     (step_o),
    .head       (head),
    .head_valid (head_valid),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  bit known    = 0;

  // model: running flag, ticks into current period, position (bounce as phase 0..13)
  bit m_busy, m_hv, m_step, m_done, m_pend, m_prun;
  int m_ticks, m_speed, m_mode, m_head, m_phase, m_pspeed, m_pmode;

  int st_cyc[$];
  int st_head[$];
  int dn_cyc[$];
  bit obs_rdy[0:4095];
  bit obs_hv[0:4095];
  bit obs_busy[0:4095];
  int obs_head[0:4095];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
  endtask

  function automatic int period(input int s);
    return (s + 1) << (PW - 3);
  endfunction

  task automatic m_advance(input int mode);
    case (mode)
      1: m_head = (m_head + 7) % 8;
      2: begin
        m_phase = (m_phase + 1) % 14;
        m_head  = (m_phase <= 7) ? m_phase : 14 - m_phase;
      end
      default: m_head = (m_head + 1) % 8;
    endcase
  endtask

  task automatic model_step(input bit r, input bit v, input int s, input int m, input bit rn);
    bit acc;
    m_step = 0;
    m_done = 0;
    acc = v && !m_pend;
    if (!r) begin
      m_busy = 0; m_hv = 0; m_pend = 0; m_ticks = 0; m_head = 0; m_phase = 0;
      m_speed = 0; m_mode = 0;
    end else if (!m_busy) begin
      if (m_pend) begin
        m_pend  = 0;
        m_speed = m_pspeed;
        m_mode  = m_pmode;
        if (m_prun) begin
          m_busy = 1; m_hv = 1; m_ticks = 0; m_phase = 0;
          m_head = (m_mode == 1) ? 7 : 0;
        end else begin
          m_hv = 0;
        end
      end else if (acc) begin
        m_pend = 1; m_pspeed = s; m_pmode = m; m_prun = rn;
      end
    end else begin
      if (m_ticks == period(m_speed) - 1) begin
        m_ticks = 0;
        if (m_pend) begin
          m_pend  = 0;
          m_speed = m_pspeed;
          m_mode  = m_pmode;
          if (!m_prun) begin
            m_busy = 0; m_hv = 0;
          end else begin
            m_step = 1;
            if (m_mode == 3) m_head = 0;
            else begin
              m_phase = m_head;
              m_advance(m_mode);
            end
          end
        end else begin
          m_step = 1;
          m_advance(m_mode);
          if (m_mode == 3 && m_head == 7) begin
            m_busy = 0; m_done = 1;
          end
        end
      end else begin
        m_ticks++;
      end
      if (acc) begin
        m_pend = 1; m_pspeed = s; m_pmode = m; m_prun = rn;
      end
    end
  endtask

  task automatic compare_outputs();
    chk("cfg_ready", int'(cfg_ready), int'(!m_pend));
    chk("busy", int'(busy), int'(m_busy));
    chk("head_valid", int'(head_valid), int'(m_hv));
    chk("step_o", int'(step_o), int'(m_step));
    chk("done", int'(done), int'(m_done));
    if (m_hv) chk("head", int'(head), m_head);
    if (step_o) begin
      st_cyc.push_back(cyc);
      st_head.push_back(int'(head));
    end
    if (done) dn_cyc.push_back(cyc);
    if (cyc < 4096) begin
      obs_rdy[cyc]  = cfg_ready;
      obs_hv[cyc]   = head_valid;
      obs_busy[cyc] = busy;
      obs_head[cyc] = int'(head);
    end
  endtask

  task automatic tick(input logic r, input logic v, input logic [2:0] s,
                      input logic [1:0] m, input logic rn);
    @(negedge clk);
    cyc++;
    if (known) compare_outputs();
    reset_n   = r;
    cfg_valid = v;
    cfg_speed = s;
    cfg_mode  = m;
    cfg_run   = rn;
    model_step(r, v, int'(s), int'(m), rn);
    if (!r) known = 1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b1, 1'b0, 3'd0, 2'd0, 1'b0);
  endtask

  task automatic reset3();
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 3'd0, 2'd0, 1'b0);
  endtask

  task automatic clear_obs();
    st_cyc.delete();
    st_head.delete();
    dn_cyc.delete();
  endtask

  int a;
  int bseq[15];

  initial begin
    reset_n = 1'b0; cfg_valid = 1'b0; cfg_speed = 3'd0; cfg_mode = 2'd0; cfg_run = 1'b0;
    bseq = '{1, 2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1, 0, 1};

    // forward, T=7: first step 9 cycles after the accept edge, then every 8
    reset3();
    clear_obs();
    tick(1'b1, 1'b1, 3'd0, 2'd0, 1'b1);
    a = cyc;
    idle(80);
    chk("fwd_nsteps", st_cyc.size(), 9);
    for (int k = 0; k < 9 && k < st_cyc.size(); k++) begin
      chk("fwd_step_time", st_cyc[k] - a, 10 + 8 * k);
      chk("fwd_head", st_head[k], (k + 1) % 8);
    end

    // reset held 3 cycles during RUN
    reset3();
    @(posedge clk); #1;
    chk("rst_head", int'(head), 0);
    chk("rst_head_valid", int'(head_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_step", int'(step_o), 0);
    chk("rst_ready", int'(cfg_ready), 1);

    // reverse, T=31: start at 7, step every 32
    clear_obs();
    tick(1'b1, 1'b1, 3'd3, 2'd1, 1'b1);
    a = cyc;
    idle(328);
    chk("rev_start_head", obs_head[a + 2], 7);
    chk("rev_nsteps", st_cyc.size(), 10);
    for (int k = 0; k < 9 && k < st_cyc.size(); k++) begin
      chk("rev_step_time", st_cyc[k] - a, 34 + 32 * k);
      chk("rev_head", st_head[k], (6 - k + 8) % 8);
    end

    // bounce, T=7: endpoints appear once per turn
    reset3();
    clear_obs();
    tick(1'b1, 1'b1, 3'd0, 2'd2, 1'b1);
    a = cyc;
    idle(130);
    chk("bnc_nsteps", st_cyc.size(), 16);
    for (int k = 0; k < 15 && k < st_head.size(); k++) chk("bnc_head", st_head[k], bseq[k]);

    // single-shot: 7 steps, done with the last, then parked
    reset3();
    clear_obs();
    tick(1'b1, 1'b1, 3'd0, 2'd3, 1'b1);
    a = cyc;
    idle(120);
    chk("one_nsteps", st_cyc.size(), 7);
    for (int k = 0; k < 7 && k < st_head.size(); k++) chk("one_head", st_head[k], k + 1);
    chk("one_ndone", dn_cyc.size(), 1);
    if (dn_cyc.size() > 0) chk("one_done_time", dn_cyc[0] - a, 58);
    @(posedge clk); #1;
    chk("one_busy", int'(busy), 0);
    chk("one_head_held", int'(head), 7);
    chk("one_head_valid", int'(head_valid), 1);

    // mid-run reconfiguration: forward -> reverse s=1 -> stop
    reset3();
    clear_obs();
    tick(1'b1, 1'b1, 3'd0, 2'd0, 1'b1);
    a = cyc;
    idle(12);
    tick(1'b1, 1'b1, 3'd1, 2'd1, 1'b1);
    idle(6);
    tick(1'b1, 1'b1, 3'd0, 2'd0, 1'b0);
    idle(30);
    chk("mid_ready_low_a", int'(obs_rdy[a + 14]), 0);
    chk("mid_ready_low_b", int'(obs_rdy[a + 17]), 0);
    chk("mid_ready_back", int'(obs_rdy[a + 18]), 1);
    chk("mid_nsteps", st_cyc.size(), 2);
    if (st_cyc.size() >= 2) begin
      chk("mid_switch_time", st_cyc[1] - a, 18);
      chk("mid_switch_head", st_head[1], 0);
    end
    chk("mid_hv_before_stop", int'(obs_hv[a + 33]), 1);
    chk("mid_hv_stop", int'(obs_hv[a + 34]), 0);
    chk("mid_busy_stop", int'(obs_busy[a + 34]), 0);

    // random traffic against the model
    for (int i = 0; i < 20000; i++) begin
      tick(logic'($urandom_range(0, 999) != 0),
           logic'($urandom_range(0, 29) == 0),
           3'($urandom_range(0, 7)),
           2'($urandom_range(0, 3)),
           logic'($urandom_range(0, 5) != 0));
    end
    idle(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
